// File: rtl/microchip_reset_sequencer.sv
// Reset / clock-enable sequencer for banks of SLE registers: holds banks in reset until PLL
// lock is stable, releases them one by one, then enables all; quiesces EN before resets on abort.
module microchip_reset_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int RELEASE_DELAY = 4,
    parameter int SYNC_DEPTH    = 2
) (
    input  logic                  CLK,
    input  logic                  ALn,
    input  logic                  LOCK,
    input  logic                  REQ_RST,
    output logic [NUM_STAGES-1:0] STAGE_ALn,
    output logic [NUM_STAGES-1:0] STAGE_EN,
    output logic                  DONE,
    output logic [2:0]            STATE
);

    localparam int              KW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [7:0]      CNT_RELOAD = 8'(RELEASE_DELAY - 1);
    localparam logic [KW-1:0]   K_LAST     = KW'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        RELEASE = 3'd1,
        ENABLE  = 3'd2,
        RUN     = 3'd3,
        QUIESCE = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [7:0]              cnt_r, cnt_s;
    logic [KW-1:0]           k_r, k_s;
    logic [NUM_STAGES-1:0]   aln_r, aln_s;
    logic [NUM_STAGES-1:0]   en_r, en_s;
    logic                    done_r, done_s;
    logic [SYNC_DEPTH-1:0]   sync_r;
    logic                    lock_s;
    logic                    abort_s;

    // LOCK is asynchronous to CLK; the chain resets to "unlocked" so banks stay held.
    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], LOCK};
        end
    end

    assign lock_s  = sync_r[SYNC_DEPTH-1];
    assign abort_s = !lock_s || REQ_RST;

    // FSM state and registered outputs.
    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            state_r <= HOLD;
            cnt_r   <= 8'd0;
            k_r     <= '0;
            aln_r   <= '0;
            en_r    <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            k_r     <= k_s;
            aln_r   <= aln_s;
            en_r    <= en_s;
            done_r  <= done_s;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        k_s     = k_r;
        aln_s   = aln_r;
        en_s    = en_r;
        done_s  = done_r;
        case (state_r)
            HOLD: begin
                aln_s  = '0;
                en_s   = '0;
                done_s = 1'b0;
                if (!abort_s) begin
                    cnt_s   = CNT_RELOAD;
                    k_s     = '0;
                    state_s = RELEASE;
                end else begin
                    state_s = HOLD;
                end
            end
            RELEASE: begin
                en_s   = '0;
                done_s = 1'b0;
                if (abort_s) begin
                    aln_s   = '0;
                    state_s = HOLD;
                end else if (cnt_r == 8'd0) begin
                    // Releases accumulate: only the bit for stage k is raised.
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (k_r == KW'(i)) begin
                            aln_s[i] = 1'b1;
                        end else begin
                            aln_s[i] = aln_r[i];
                        end
                    end
                    cnt_s = CNT_RELOAD;
                    if (k_r == K_LAST) begin
                        state_s = ENABLE;
                    end else begin
                        k_s = k_r + KW'(1);
                    end
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ENABLE: begin
                if (abort_s) begin
                    aln_s   = '0;
                    en_s    = '0;
                    done_s  = 1'b0;
                    state_s = HOLD;
                end else begin
                    en_s    = '1;
                    done_s  = 1'b1;
                    state_s = RUN;
                end
            end
            RUN: begin
                aln_s = '1;
                if (abort_s) begin
                    // EN drops first; resets follow one edge later from QUIESCE.
                    en_s    = '0;
                    done_s  = 1'b0;
                    state_s = QUIESCE;
                end else begin
                    en_s    = '1;
                    done_s  = 1'b1;
                    state_s = RUN;
                end
            end
            QUIESCE: begin
                aln_s   = '0;
                en_s    = '0;
                done_s  = 1'b0;
                state_s = HOLD;
            end
            default: begin
                cnt_s   = 8'd0;
                k_s     = '0;
                aln_s   = '0;
                en_s    = '0;
                done_s  = 1'b0;
                state_s = HOLD;
            end
        endcase
    end

    assign STAGE_ALn = aln_r;
    assign STAGE_EN  = en_r;
    assign DONE      = done_r;
    assign STATE     = state_r;

endmodule

// File: tb/tb_microchip_reset_sequencer.sv
// Randomized bench for microchip_reset_sequencer: three parameter sets share stimulus and
// are checked every cycle against an elapsed-time reference model of the release schedule.
module tb_microchip_reset_sequencer;

    logic CLK = 1'b0;
    logic ALn;
    logic LOCK;
    logic REQ_RST;

    logic [3:0]  aln0, en0;
    logic        done0;
    logic [2:0]  st0;
    logic [0:0]  aln1, en1;
    logic        done1;
    logic [2:0]  st1;
    logic [15:0] aln2, en2;
    logic        done2;
    logic [2:0]  st2;

    int tests_run    = 0;
    int tests_failed = 0;

    int n_a  [3] = '{4, 1, 16};
    int rd_a [3] = '{4, 1, 255};
    int sd_a [3] = '{2, 4, 3};
    int sync_m [3];
    int mode_m [3];
    int t_m    [3];
    int e;

    always #5 CLK = ~CLK;

    microchip_reset_sequencer #(.NUM_STAGES(4), .RELEASE_DELAY(4), .SYNC_DEPTH(2)) dut0 (
        .CLK(CLK), .ALn(ALn), .LOCK(LOCK), .REQ_RST(REQ_RST),
        .STAGE_ALn(aln0), .STAGE_EN(en0), .DONE(done0), .STATE(st0));

    microchip_reset_sequencer #(.NUM_STAGES(1), .RELEASE_DELAY(1), .SYNC_DEPTH(4)) dut1 (
        .CLK(CLK), .ALn(ALn), .LOCK(LOCK), .REQ_RST(REQ_RST),
        .STAGE_ALn(aln1), .STAGE_EN(en1), .DONE(done1), .STATE(st1));

    microchip_reset_sequencer #(.NUM_STAGES(16), .RELEASE_DELAY(255), .SYNC_DEPTH(3)) dut2 (
        .CLK(CLK), .ALn(ALn), .LOCK(LOCK), .REQ_RST(REQ_RST),
        .STAGE_ALn(aln2), .STAGE_EN(en2), .DONE(done2), .STATE(st2));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] ones(input int n);
        return 16'((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [15:0] obs_aln(input int d);
        case (d)
            0:       return 16'(aln0);
            1:       return 16'(aln1);
            default: return aln2;
        endcase
    endfunction

    function automatic logic [15:0] obs_en(input int d);
        case (d)
            0:       return 16'(en0);
            1:       return 16'(en1);
            default: return en2;
        endcase
    endfunction

    function automatic logic obs_done(input int d);
        case (d)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [2:0] obs_state(input int d);
        case (d)
            0:       return st0;
            1:       return st1;
            default: return st2;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            sync_m[d] = 0;
            mode_m[d] = 0;
            t_m[d]    = 0;
        end
    endtask

    // One rising edge of the reference model: mode 0 hold, 1 releasing, 2 enable, 3 run, 4 quiesce.
    task automatic model_step(input int d);
        int  ls;
        bit  ab;
        ls = (sync_m[d] >> (sd_a[d] - 1)) & 1;
        ab = (ls == 0) || REQ_RST;
        sync_m[d] = ((sync_m[d] << 1) | (LOCK ? 1 : 0)) & ((1 << sd_a[d]) - 1);
        case (mode_m[d])
            0: if (!ab) begin mode_m[d] = 1; t_m[d] = 0; end
            1: begin
                if (ab) mode_m[d] = 0;
                else begin
                    t_m[d]++;
                    if (t_m[d] == n_a[d] * rd_a[d]) mode_m[d] = 2;
                end
            end
            2: mode_m[d] = ab ? 0 : 3;
            3: if (ab) mode_m[d] = 4;
            default: mode_m[d] = 0;
        endcase
    endtask

    task automatic check_all();
        logic [15:0] ea, ee;
        for (int d = 0; d < 3; d++) begin
            case (mode_m[d])
                0:       ea = 16'd0;
                1:       ea = ones(t_m[d] / rd_a[d]);
                default: ea = ones(n_a[d]);
            endcase
            ee = (mode_m[d] == 3) ? ones(n_a[d]) : 16'd0;
            check_eq($sformatf("d%0d_stage_aln", d), 32'(obs_aln(d)), 32'(ea));
            check_eq($sformatf("d%0d_stage_en", d), 32'(obs_en(d)), 32'(ee));
            check_eq($sformatf("d%0d_done", d), 32'(obs_done(d)), (mode_m[d] == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("d%0d_state", d), 32'(obs_state(d)), 32'(mode_m[d]));
        end
    endtask

    // Advance one clock: model steps on the rising edge, outputs checked 1 time unit later.
    task automatic cycle();
        @(posedge CLK);
        if (ALn) begin
            for (int d = 0; d < 3; d++) model_step(d);
            e++;
        end
        #1;
        check_all();
        @(negedge CLK);
    endtask

    task automatic async_reset();
        ALn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        @(negedge CLK);
        ALn = 1'b1;
        e   = 0;
    endtask

    initial begin
        int r;
        ALn     = 1'b1;
        LOCK    = 1'b1;
        REQ_RST = 1'b0;
        e       = 0;
        #1 ALn = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (3) @(negedge CLK);
        ALn = 1'b1;

        // Power-up with steady lock; long enough for the 16x255 instance to reach RUN.
        repeat (4200) begin
            cycle();
            case (e)
                3:  check_eq("pu_state_e3", 32'(st0), 32'd1);
                7:  check_eq("pu_aln_e7", 32'(aln0), 32'h1);
                11: check_eq("pu_aln_e11", 32'(aln0), 32'h3);
                15: check_eq("pu_aln_e15", 32'(aln0), 32'h7);
                19: begin
                    check_eq("pu_aln_e19", 32'(aln0), 32'hF);
                    check_eq("pu_en_e19", 32'(en0), 32'h0);
                end
                20: begin
                    check_eq("pu_en_e20", 32'(en0), 32'hF);
                    check_eq("pu_done_e20", 32'(done0), 32'd1);
                end
                default: ;
            endcase
        end
        check_eq("sweep_done16", 32'(done2), 32'd1);
        check_eq("sweep_en16", 32'(en2), 32'hFFFF);
        check_eq("sweep_done1", 32'(done1), 32'd1);

        // Software reset pulse while running.
        REQ_RST = 1'b1;
        cycle();
        check_eq("sw_en_A", 32'(en0), 32'h0);
        check_eq("sw_done_A", 32'(done0), 32'd0);
        check_eq("sw_aln_A", 32'(aln0), 32'hF);
        check_eq("sw_state_A", 32'(st0), 32'd4);
        REQ_RST = 1'b0;
        cycle();
        check_eq("sw_aln_A1", 32'(aln0), 32'h0);
        check_eq("sw_state_A1", 32'(st0), 32'd0);
        repeat (40) cycle();
        check_eq("sw_rerun_done", 32'(done0), 32'd1);

        // Asynchronous reset in RUN, mid-cycle.
        #2;
        async_reset();
        check_eq("ar_state", 32'(st0), 32'd0);

        // Randomized lock loss, software requests and occasional async resets.
        repeat (3000) begin
            r = $urandom_range(0, 999);
            if (r < 25)       LOCK = ~LOCK;
            if (r >= 25 && r < 40) REQ_RST = 1'b1;
            else              REQ_RST = 1'b0;
            if (r == 999) begin
                #2;
                async_reset();
            end
            cycle();
        end

        LOCK    = 1'b1;
        REQ_RST = 1'b0;
        repeat (30) cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/microchip_reset_sequencer.md
# microchip_reset_sequencer

Reset and clock-enable sequencer for banks of SLE registers in the Microchip flow. It holds each bank in asynchronous reset through its active-low ALn pin until the PLL lock is stable. It then releases the banks one at a time with a programmable gap, and finally drives all bank EN pins high together. On lock loss or a software reset request it quiesces EN first, then reasserts all resets. The block sits between the clock/PLL infrastructure and the mapped SLE fabric.

## Interface

- NUM_STAGES, 4, number of SLE banks sequenced; 1..16.
- RELEASE_DELAY, 4, CLK cycles between successive stage releases; 1..255.
- SYNC_DEPTH, 2, flops in the LOCK synchronizer; 2..4.

Ports:

- CLK  in  1  single clock; all state is on its rising edge.
- ALn  in  1  reset, asynchronous assert, active-low.
- LOCK  in  1  PLL lock; asynchronous to CLK; synchronized internally.
- REQ_RST  in  1  synchronous software reset request, level-sensitive, active-high.
- STAGE_ALn  out  NUM_STAGES  per-bank active-low reset, wired to SLE ALn; bit 0 is released first.
- STAGE_EN  out  NUM_STAGES  per-bank clock enable, wired to SLE EN.
- DONE  out  1  high while in RUN.
- STATE  out  3  current FSM state for debug.

## Operation

- LOCK passes through a SYNC_DEPTH flop chain, reset to 0, producing lock_s.
- abort = !lock_s || REQ_RST.
- FSM states and encodings:
  - HOLD = 0: STAGE_ALn all 0, STAGE_EN all 0.
    - If !abort: load cnt = RELEASE_DELAY-1, k = 0, go to RELEASE.
  - RELEASE = 1:
    - If abort: go to HOLD and drive STAGE_ALn all 0 at the same edge.
    - Else if cnt == 0: set STAGE_ALn[k] = 1 and reload cnt.
      - If k == NUM_STAGES-1, go to ENABLE; otherwise k++.
    - Else cnt--.
  - ENABLE = 2:
    - If abort: go to HOLD with all resets asserted.
    - Else: STAGE_EN all 1, DONE = 1, go to RUN.
  - RUN = 3:
    - If abort: STAGE_EN all 0, DONE = 0, go to QUIESCE.
    - STAGE_ALn stays all 1.
  - QUIESCE = 4: unconditionally STAGE_ALn all 0, go to HOLD.
- Arithmetic widths:
  - cnt is 8 bits.
  - k is clog2(NUM_STAGES) bits, minimum 1.
  - Neither wraps: cnt reloads at 0, and k stops at NUM_STAGES-1.
- Stage releases are cumulative. Once a bit of STAGE_ALn is released it stays 1 until HOLD or QUIESCE clears all bits.
- STATE encodings 5..7 are illegal. If reached, the next edge goes to HOLD with all outputs at their reset values.

## Timing

- ALn low forces, asynchronously and without waiting for CLK:
  - STAGE_ALn = 0, STAGE_EN = 0, DONE = 0, STATE = HOLD.
  - cnt = 0, k = 0, synchronizer = 0.
- ALn is deasserted synchronously by the upstream reset synchronizer. The sequencer only requires ALn to be high at an edge.
- Edge numbering: edge 1 is the first rising CLK edge with ALn high.
- With LOCK steady high and REQ_RST low:
  - lock_s = 1 after edge SYNC_DEPTH.
  - The FSM enters RELEASE at edge SYNC_DEPTH+1 (call it E).
- Stage k release: STAGE_ALn[k] rises at edge E + (k+1)*RELEASE_DELAY.
- Enable: STAGE_EN and DONE rise exactly one edge after the last stage release.
- Shutdown from RUN, where abort is first seen at edge A:
  - STAGE_EN and DONE fall at A.
  - STAGE_ALn falls at A+1.
  - STATE = HOLD after A+1.
  - EN is therefore always low for at least one cycle before ALn asserts.
- Shutdown from RELEASE or ENABLE: resets assert at the first edge that sees abort. EN is still 0 in these states.
- Abort cleared while in HOLD: release restarts from stage 0 with a full RELEASE_DELAY.
- Minimum HOLD dwell is 1 cycle.
- REQ_RST and lock loss asserted in the same cycle are treated as one abort.
- A LOCK glitch shorter than one CLK period may be missed by the synchronizer. A glitch spanning an edge that propagates to lock_s is honoured.
- ALn asserted mid-sequence or in RUN overrides everything immediately.

## Test plan

- **Power-up** (defaults; LOCK = 1, REQ_RST = 0; release ALn before edge 1):
  - STATE = 1 at edge 3.
  - STAGE_ALn: 0001 at edge 7, 0011 at edge 11, 0111 at edge 15, 1111 at edge 19.
  - STAGE_EN = 1111 and DONE = 1 at edge 20.
- **Late lock** (LOCK rises after edge 10):
  - Block stays in HOLD with all outputs 0 until lock_s rises.
  - First release occurs RELEASE_DELAY edges after RELEASE entry.
- **Software reset in RUN** (REQ_RST = 1 for one cycle at edge A):
  - STAGE_EN = 0000 and DONE = 0 at A.
  - STAGE_ALn = 0000 at A+1.
  - STATE goes 3 -> 4 -> 0, then the full sequence reruns.
- **Lock loss mid-release** (LOCK = 0 after stage 1 is released):
  - STAGE_ALn = 0000 at the first edge where lock_s = 0.
  - STAGE_EN stays 0000 throughout.
  - Re-lock restarts from stage 0.
- **Async reset in RUN** (ALn low between edges):
  - All outputs go to 0 before the next CLK edge.
  - STATE = 0.
- **Parameter sweep** (NUM_STAGES = 1 with RELEASE_DELAY = 1; NUM_STAGES = 16 with RELEASE_DELAY = 255; SYNC_DEPTH = 4):
  - Release edges match E + (k+1)*RELEASE_DELAY.
  - Enable edge follows the last release by 1.
